// File: rtl/seq_adder_ctrl.sv
// Byte-serial add/subtract sequencer. One 8-bit carry-lookahead slice is reused
// over WIDTH/8 cycles, with a START/BUSY/DONE handshake toward the ALU control FSM.

module CLAAdder8b (
   input  logic [7:0] A,
   input  logic [7:0] B,
   input  logic       CIN,
   output logic [7:0] S,
   output logic       COUT
);
   logic [7:0] g;
   logic [7:0] p;
   logic [8:0] cy;
   logic       acc;
   logic       prop;

   // Each carry is built directly from generate/propagate terms, not from the previous carry.
   always_comb begin
      // NOTE: every variable gets a value before any branch or loop, so no latch is inferred.
      g    = A & B;
      p    = A ^ B;
      cy   = '0;
      acc  = 1'b0;
      prop = 1'b0;
      cy[0] = CIN;
      for (int i = 0; i < 8; i++) begin
         acc  = g[i];
         prop = p[i];
         for (int j = i - 1; j >= 0; j--) begin
            acc  = acc | (prop & g[j]);
            prop = prop & p[j];
         end
         cy[i+1] = acc | (prop & CIN);
      end
      S    = p ^ cy[7:0];
      COUT = cy[8];
   end
endmodule

module seq_adder_ctrl #(
   parameter int WIDTH = 64
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             START,
   input  logic             SUB,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             BUSY,
   output logic             DONE,
   output logic [WIDTH-1:0] S,
   output logic             COUT,
   output logic             OVF
);
   localparam int NBYTES = WIDTH / 8;
   localparam int IW     = $clog2(NBYTES);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] FIN  = 2'd2;

   logic [1:0]       state;
   logic [IW-1:0]    idx;
   logic             c;
   logic [WIDTH-1:0] ra;
   logic [WIDTH-1:0] rb;

   logic [7:0] slice_sum;
   logic       slice_cout;
   logic       accept;
   logic       last;

   CLAAdder8b u_cla (
      .A    (ra[8*idx +: 8]),
      .B    (rb[8*idx +: 8]),
      .CIN  (c),
      .S    (slice_sum),
      .COUT (slice_cout)
   );

   assign accept = START && ((state == IDLE) || (state == FIN));
   assign last   = (idx == IW'(NBYTES - 1));
   assign BUSY   = (state == RUN);
   assign DONE   = (state == FIN);

   // NOTE: all state registers use non-blocking assignments so every update sees pre-edge values.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= IDLE;
         idx   <= '0;
         c     <= 1'b0;
         ra    <= '0;
         rb    <= '0;
         S     <= '0;
         COUT  <= 1'b0;
         OVF   <= 1'b0;
      end else begin
         case (state)
            IDLE, FIN: begin
               if (accept) begin
                  // Subtract is A + ~B + 1: the +1 enters as the first carry-in.
                  ra    <= A;
                  rb    <= SUB ? ~B : B;
                  c     <= SUB;
                  idx   <= '0;
                  S     <= '0;
                  COUT  <= 1'b0;
                  OVF   <= 1'b0;
                  state <= RUN;
               end else begin
                  state <= IDLE;
               end
            end
            RUN: begin
               S[8*idx +: 8] <= slice_sum;
               c             <= slice_cout;
               if (last) begin
                  state <= FIN;
                  COUT  <= slice_cout;
                  OVF   <= (ra[WIDTH-1] == rb[WIDTH-1]) && (slice_sum[7] != ra[WIDTH-1]);
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
